// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
//
// Time-of-day core for the VGA clock. A free-running prescaler produces a
// one-cycle 1 Hz strobe. The strobe and the three adjust-button pulses are
// latched as pending requests. A fixed-priority arbiter applies at most one
// request per cycle to the live BCD hh:mm:ss registers. The renderer sees a
// snapshot of those registers that only reloads on frame_start, so digits never
// change in the middle of a frame.
//
// Ports
//   px_clk         pixel clock, rising edge
//   reset          synchronous, active-high
//   adj_sec_pulse  one-cycle request: +1 on the seconds field (no carry)
//   adj_min_pulse  one-cycle request: +1 on the minutes field (no carry)
//   adj_hrs_pulse  one-cycle request: +1 on the hours field
//   frame_start    one-cycle pulse at pixel (0,0); reloads the snapshot
//   sec_strobe     one-cycle pulse in the prescaler wrap cycle
//   hrs_d/hrs_u    hours tens/units snapshot
//   min_d/min_u    minutes tens/units snapshot
//   sec_d/sec_u    seconds tens/units snapshot
// -----------------------------------------------------------------------------
module time_keeper #(
    parameter int TICKS_PER_SEC = 31_500_000,
    parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       adj_sec_pulse,
    input  logic       adj_min_pulse,
    input  logic       adj_hrs_pulse,
    input  logic       frame_start,
    output logic       sec_strobe,
    output logic [1:0] hrs_d,
    output logic [3:0] hrs_u,
    output logic [2:0] min_d,
    output logic [3:0] min_u,
    output logic [2:0] sec_d,
    output logic [3:0] sec_u
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [6:0]       BCD_59   = {3'd5, 4'd9};
    localparam logic [5:0]       BCD_23   = {2'd2, 4'd3};

    // Pending-request bit positions, in descending priority.
    localparam int P_TICK = 0;
    localparam int P_SEC  = 1;
    localparam int P_MIN  = 2;
    localparam int P_HRS  = 3;

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pend;
    logic [6:0]       r_sec;      // {tens[2:0], units[3:0]}
    logic [6:0]       r_min;      // {tens[2:0], units[3:0]}
    logic [5:0]       r_hrs;      // {tens[1:0], units[3:0]}

    logic [1:0]       r_hrs_d_snap;
    logic [3:0]       r_hrs_u_snap;
    logic [2:0]       r_min_d_snap;
    logic [3:0]       r_min_u_snap;
    logic [2:0]       r_sec_d_snap;
    logic [3:0]       r_sec_u_snap;

    logic             w_wrap;
    logic [3:0]       w_req;
    logic [3:0]       w_grant;
    logic [3:0]       w_pend_nxt;
    logic [6:0]       w_sec_nxt;
    logic [6:0]       w_min_nxt;
    logic [5:0]       w_hrs_nxt;

    // BCD 00..59 increment, wrapping 59 -> 00.
    function automatic logic [6:0] f_inc60(input logic [6:0] v);
        logic [6:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[6:4] == 3'd5) r = 7'd0;
            else                r = {v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD 00..23 increment: 09 -> 10, 19 -> 20, 23 -> 00.
    function automatic logic [5:0] f_inc24(input logic [5:0] v);
        logic [5:0] r;
        if (v == BCD_23)            r = 6'd0;
        else if (v[3:0] == 4'd9)    r = {v[5:4] + 2'd1, 4'd0};
        else                        r = {v[5:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign w_wrap     = (r_cnt == CNT_LAST);
    assign sec_strobe = w_wrap;
    assign w_req      = {adj_hrs_pulse, adj_min_pulse, adj_sec_pulse, w_wrap};

    // Fixed-priority one-hot grant over the pending bits.
    always_comb begin
        w_grant = 4'b0000;
        if (r_pend[P_TICK])     w_grant[P_TICK] = 1'b1;
        else if (r_pend[P_SEC]) w_grant[P_SEC]  = 1'b1;
        else if (r_pend[P_MIN]) w_grant[P_MIN]  = 1'b1;
        else if (r_pend[P_HRS]) w_grant[P_HRS]  = 1'b1;
    end

    // Clearing the serviced bit before OR-ing in new requests keeps a request
    // that arrives in its own service cycle; repeats on a waiting bit merge.
    assign w_pend_nxt = (r_pend & ~w_grant) | w_req;

    always_comb begin
        w_sec_nxt = r_sec;
        w_min_nxt = r_min;
        w_hrs_nxt = r_hrs;
        if (w_grant[P_TICK]) begin
            // Full carry chain: only the tick ripples into higher fields.
            w_sec_nxt = f_inc60(r_sec);
            if (r_sec == BCD_59) begin
                w_min_nxt = f_inc60(r_min);
                if (r_min == BCD_59) begin
                    w_hrs_nxt = f_inc24(r_hrs);
                end
            end
        end else if (w_grant[P_SEC]) begin
            w_sec_nxt = f_inc60(r_sec);
        end else if (w_grant[P_MIN]) begin
            w_min_nxt = f_inc60(r_min);
        end else if (w_grant[P_HRS]) begin
            w_hrs_nxt = f_inc24(r_hrs);
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pend       <= 4'b0000;
            r_sec        <= 7'd0;
            r_min        <= 7'd0;
            r_hrs        <= 6'd0;
            r_hrs_d_snap <= 2'd0;
            r_hrs_u_snap <= 4'd0;
            r_min_d_snap <= 3'd0;
            r_min_u_snap <= 4'd0;
            r_sec_d_snap <= 3'd0;
            r_sec_u_snap <= 4'd0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_pend <= w_pend_nxt;
            r_sec  <= w_sec_nxt;
            r_min  <= w_min_nxt;
            r_hrs  <= w_hrs_nxt;
            // Snapshot takes the pre-update live value of this cycle.
            if (frame_start) begin
                r_hrs_d_snap <= r_hrs[5:4];
                r_hrs_u_snap <= r_hrs[3:0];
                r_min_d_snap <= r_min[6:4];
                r_min_u_snap <= r_min[3:0];
                r_sec_d_snap <= r_sec[6:4];
                r_sec_u_snap <= r_sec[3:0];
            end
        end
    end

    assign hrs_d = r_hrs_d_snap;
    assign hrs_u = r_hrs_u_snap;
    assign min_d = r_min_d_snap;
    assign min_u = r_min_u_snap;
    assign sec_d = r_sec_d_snap;
    assign sec_u = r_sec_u_snap;

endmodule

// File: tb/tb_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_time_keeper
//
// Two instances: u_small (TICKS_PER_SEC=4) for strobe/arbitration timing and
// u_big (TICKS_PER_SEC=400) so long adjust sequences finish before a tick.
// Cycle 1 is the first cycle with reset low. Inputs are driven and outputs
// sampled on the falling edge. With frame_start held high the snapshot seen in
// cycle c equals the live time after the rising edge ending cycle c-2.
// Times are compared as 24-bit HHMMSS nibble values.
// -----------------------------------------------------------------------------
module tb_time_keeper;

    localparam int TPS_S = 4;
    localparam int TPS_B = 400;

    logic px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    logic       s_reset, s_adj_sec, s_adj_min, s_adj_hrs, s_frame, s_strobe;
    logic [1:0] s_hd;
    logic [3:0] s_hu, s_mu, s_su;
    logic [2:0] s_md, s_sd;

    logic       b_reset, b_adj_sec, b_adj_min, b_adj_hrs, b_frame, b_strobe;
    logic [1:0] b_hd;
    logic [3:0] b_hu, b_mu, b_su;
    logic [2:0] b_md, b_sd;

    logic [23:0] s_time, b_time;
    assign s_time = {2'b00, s_hd, s_hu, 1'b0, s_md, s_mu, 1'b0, s_sd, s_su};
    assign b_time = {2'b00, b_hd, b_hu, 1'b0, b_md, b_mu, 1'b0, b_sd, b_su};

    int checks = 0;
    int errors = 0;

    time_keeper #(.TICKS_PER_SEC(TPS_S)) u_small (
        .px_clk(px_clk), .reset(s_reset),
        .adj_sec_pulse(s_adj_sec), .adj_min_pulse(s_adj_min), .adj_hrs_pulse(s_adj_hrs),
        .frame_start(s_frame), .sec_strobe(s_strobe),
        .hrs_d(s_hd), .hrs_u(s_hu), .min_d(s_md), .min_u(s_mu), .sec_d(s_sd), .sec_u(s_su)
    );

    time_keeper #(.TICKS_PER_SEC(TPS_B)) u_big (
        .px_clk(px_clk), .reset(b_reset),
        .adj_sec_pulse(b_adj_sec), .adj_min_pulse(b_adj_min), .adj_hrs_pulse(b_adj_hrs),
        .frame_start(b_frame), .sec_strobe(b_strobe),
        .hrs_d(b_hd), .hrs_u(b_hu), .min_d(b_md), .min_u(b_mu), .sec_d(b_sd), .sec_u(b_su)
    );

    function automatic logic [23:0] hms(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // ---- stimulus helpers (no checking) ----
    task automatic small_reset();
        @(negedge px_clk);
        s_reset = 1'b1; s_adj_sec = 1'b0; s_adj_min = 1'b0; s_adj_hrs = 1'b0; s_frame = 1'b0;
        @(negedge px_clk);
        @(negedge px_clk);
        s_reset = 1'b0;
    endtask

    task automatic big_reset();
        @(negedge px_clk);
        b_reset = 1'b1; b_adj_sec = 1'b0; b_adj_min = 1'b0; b_adj_hrs = 1'b0; b_frame = 1'b0;
        @(negedge px_clk);
        @(negedge px_clk);
        b_reset = 1'b0;
    endtask

    // which: 0 = sec, 1 = min, 2 = hrs. One pulse followed by one idle cycle.
    task automatic big_pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            b_adj_sec = (which == 0);
            b_adj_min = (which == 1);
            b_adj_hrs = (which == 2);
            @(negedge px_clk);
            b_adj_sec = 1'b0; b_adj_min = 1'b0; b_adj_hrs = 1'b0;
            @(negedge px_clk);
        end
    endtask

    task automatic big_snap();
        b_frame = 1'b1;
        @(negedge px_clk);
        b_frame = 1'b0;
    endtask

    // ---- tests ----
    task automatic test_reset();
        @(negedge px_clk);
        s_reset = 1'b1; b_reset = 1'b1; s_frame = 1'b1; b_frame = 1'b1;
        @(negedge px_clk);
        @(negedge px_clk);
        checks++; if (s_time !== 24'h0) begin errors++; $display("FAIL reset_small_time: got %h exp 000000", s_time); end
        checks++; if (s_strobe !== 1'b0) begin errors++; $display("FAIL reset_small_strobe: got %b exp 0", s_strobe); end
        checks++; if (b_time !== 24'h0) begin errors++; $display("FAIL reset_big_time: got %h exp 000000", b_time); end
        checks++; if (b_strobe !== 1'b0) begin errors++; $display("FAIL reset_big_strobe: got %b exp 0", b_strobe); end
        s_frame = 1'b0; b_frame = 1'b0;
    endtask

    task automatic test_strobe_tick();
        logic [23:0] exp_t;
        small_reset();
        for (int c = 1; c <= 13; c++) begin
            exp_t = (c >= 11) ? hms(0, 0, 2) : (c >= 7) ? hms(0, 0, 1) : hms(0, 0, 0);
            checks++;
            if (s_strobe !== (c % 4 == 0)) begin
                errors++; $display("FAIL strobe_c%0d: got %b exp %b", c, s_strobe, (c % 4 == 0));
            end
            checks++;
            if (s_time !== exp_t) begin
                errors++; $display("FAIL tick_time_c%0d: got %h exp %h", c, s_time, exp_t);
            end
            s_frame = 1'b1;
            @(negedge px_clk);
        end
        s_frame = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [23:0] exp_t;
        small_reset();
        for (int c = 1; c <= 10; c++) begin
            exp_t = (c >= 8) ? hms(0, 1, 1) : (c == 7) ? hms(0, 0, 1) : hms(0, 0, 0);
            if (c == 4) begin
                checks++;
                if (s_strobe !== 1'b1) begin errors++; $display("FAIL simul_strobe: got %b exp 1", s_strobe); end
            end
            checks++;
            if (s_time !== exp_t) begin
                errors++; $display("FAIL simul_time_c%0d: got %h exp %h", c, s_time, exp_t);
            end
            s_frame   = 1'b1;
            s_adj_min = (c == 4);
            @(negedge px_clk);
        end
        s_frame = 1'b0; s_adj_min = 1'b0;
    endtask

    task automatic test_all_four();
        logic [23:0] exp_t;
        small_reset();
        for (int c = 1; c <= 11; c++) begin
            case (c)
                7:       exp_t = hms(0, 0, 1);
                8:       exp_t = hms(0, 0, 2);
                9:       exp_t = hms(0, 1, 2);
                10:      exp_t = hms(1, 1, 2);
                11:      exp_t = hms(1, 1, 3);
                default: exp_t = hms(0, 0, 0);
            endcase
            checks++;
            if (s_time !== exp_t) begin
                errors++; $display("FAIL all4_time_c%0d: got %h exp %h", c, s_time, exp_t);
            end
            s_frame   = 1'b1;
            s_adj_sec = (c == 4);
            s_adj_min = (c == 4);
            s_adj_hrs = (c == 4);
            @(negedge px_clk);
        end
        s_frame = 1'b0; s_adj_sec = 1'b0; s_adj_min = 1'b0; s_adj_hrs = 1'b0;
    endtask

    task automatic test_merge_loss();
        logic [23:0] exp_t;
        small_reset();
        for (int c = 1; c <= 11; c++) begin
            exp_t = (c >= 11) ? hms(0, 0, 3) : (c >= 8) ? hms(0, 0, 2) :
                    (c == 7)  ? hms(0, 0, 1) : hms(0, 0, 0);
            checks++;
            if (s_time !== exp_t) begin
                errors++; $display("FAIL merge_time_c%0d: got %h exp %h", c, s_time, exp_t);
            end
            s_frame   = 1'b1;
            s_adj_sec = (c == 4) || (c == 5);
            @(negedge px_clk);
        end
        s_frame = 1'b0; s_adj_sec = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_t;
        small_reset();
        for (int c = 1; c <= 8; c++) begin
            exp_t = (c >= 7) ? hms(0, 0, 3) : (c >= 5) ? hms(0, 0, 2) :
                    (c == 4) ? hms(0, 0, 1) : hms(0, 0, 0);
            checks++;
            if (s_time !== exp_t) begin
                errors++; $display("FAIL b2b_time_c%0d: got %h exp %h", c, s_time, exp_t);
            end
            s_frame   = 1'b1;
            s_adj_sec = (c == 1) || (c == 2);
            @(negedge px_clk);
        end
        s_frame = 1'b0; s_adj_sec = 1'b0;
    endtask

    task automatic test_snapshot_hold();
        small_reset();
        for (int c = 1; c <= 27; c++) begin
            if (c <= 22) begin
                checks++;
                if (s_time !== hms(0, 0, 0)) begin
                    errors++; $display("FAIL hold_time_c%0d: got %h exp 000000", c, s_time);
                end
            end else begin
                checks++;
                if (s_time !== hms(0, 0, 5)) begin
                    errors++; $display("FAIL hold_load_c%0d: got %h exp 000005", c, s_time);
                end
            end
            s_frame = (c == 22);
            @(negedge px_clk);
        end
        s_frame = 1'b0;
    endtask

    task automatic test_reset_midop_small();
        logic [23:0] exp_t;
        small_reset();
        for (int c = 1; c <= 4; c++) begin
            s_adj_sec = (c == 4); s_adj_min = (c == 4); s_adj_hrs = (c == 4);
            @(negedge px_clk);
        end
        s_adj_sec = 1'b0; s_adj_min = 1'b0; s_adj_hrs = 1'b0;
        s_reset = 1'b1;
        @(negedge px_clk);
        checks++;
        if (s_strobe !== 1'b0) begin errors++; $display("FAIL midop_s_strobe: got %b exp 0", s_strobe); end
        s_reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_t = (c >= 7) ? hms(0, 0, 1) : hms(0, 0, 0);
            checks++;
            if (s_strobe !== (c % 4 == 0)) begin
                errors++; $display("FAIL midop_s_strobe_c%0d: got %b exp %b", c, s_strobe, (c % 4 == 0));
            end
            checks++;
            if (s_time !== exp_t) begin
                errors++; $display("FAIL midop_s_time_c%0d: got %h exp %h", c, s_time, exp_t);
            end
            s_frame = 1'b1;
            @(negedge px_clk);
        end
        s_frame = 1'b0;
    endtask

    task automatic test_rollover();
        bit found;
        big_reset();
        big_pulse(2, 23);
        big_pulse(1, 59);
        big_pulse(0, 59);
        big_snap();
        checks++;
        if (b_time !== hms(23, 59, 59)) begin errors++; $display("FAIL roll_set: got %h exp 235959", b_time); end
        found = 1'b0;
        for (int i = 0; i < TPS_B + 10; i++) begin
            if (b_strobe) begin found = 1'b1; break; end
            @(negedge px_clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL roll_strobe_wait: got none exp strobe within %0d", TPS_B + 10); end
        @(negedge px_clk);              // tick serviced in this cycle
        b_frame = 1'b1;                 // loads the pre-update value
        @(negedge px_clk);
        checks++;
        if (b_time !== hms(23, 59, 59)) begin errors++; $display("FAIL roll_pre: got %h exp 235959", b_time); end
        @(negedge px_clk);
        b_frame = 1'b0;
        checks++;
        if (b_time !== hms(0, 0, 0)) begin errors++; $display("FAIL roll_wrap: got %h exp 000000", b_time); end
    endtask

    task automatic test_adjust_wrap();
        big_reset();
        big_pulse(2, 5);
        big_pulse(1, 59);
        big_pulse(0, 30);
        big_snap();
        checks++;
        if (b_time !== hms(5, 59, 30)) begin errors++; $display("FAIL adj_setup: got %h exp 055930", b_time); end
        big_pulse(1, 1);
        big_snap();
        checks++;
        if (b_time !== hms(5, 0, 30)) begin errors++; $display("FAIL adj_min_wrap: got %h exp 050030", b_time); end
        big_pulse(2, 19);
        big_snap();
        checks++;
        if (b_time !== hms(0, 0, 30)) begin errors++; $display("FAIL adj_hrs_wrap: got %h exp 000030", b_time); end
        big_pulse(0, 30);
        big_snap();
        checks++;
        if (b_time !== hms(0, 0, 0)) begin errors++; $display("FAIL adj_sec_wrap: got %h exp 000000", b_time); end
    endtask

    task automatic test_reset_midop_big();
        bit found;
        int c;
        big_reset();
        big_pulse(2, 12);
        big_pulse(1, 34);
        big_pulse(0, 56);
        big_snap();
        checks++;
        if (b_time !== hms(12, 34, 56)) begin errors++; $display("FAIL midop_b_setup: got %h exp 123456", b_time); end
        found = 1'b0;
        for (int i = 0; i < TPS_B + 10; i++) begin
            if (b_strobe) begin found = 1'b1; break; end
            @(negedge px_clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midop_b_strobe_wait: got none exp strobe within %0d", TPS_B + 10); end
        b_adj_sec = 1'b1; b_adj_min = 1'b1; b_adj_hrs = 1'b1;
        @(negedge px_clk);
        b_adj_sec = 1'b0; b_adj_min = 1'b0; b_adj_hrs = 1'b0;
        b_reset = 1'b1;
        @(negedge px_clk);
        checks++;
        if (b_time !== hms(0, 0, 0)) begin errors++; $display("FAIL midop_b_clear: got %h exp 000000", b_time); end
        b_reset = 1'b0;
        b_frame = 1'b1;
        c = 1;
        while (!b_strobe && c < TPS_B + 10) begin
            @(negedge px_clk);
            c++;
        end
        checks++;
        if (c !== TPS_B) begin errors++; $display("FAIL midop_b_first_strobe: got cycle %0d exp %0d", c, TPS_B); end
        checks++;
        if (b_time !== hms(0, 0, 0)) begin errors++; $display("FAIL midop_b_no_deferred: got %h exp 000000", b_time); end
        b_frame = 1'b0;
    endtask

    initial begin
        s_reset = 1'b1; s_adj_sec = 1'b0; s_adj_min = 1'b0; s_adj_hrs = 1'b0; s_frame = 1'b0;
        b_reset = 1'b1; b_adj_sec = 1'b0; b_adj_min = 1'b0; b_adj_hrs = 1'b0; b_frame = 1'b0;
        test_reset();
        test_strobe_tick();
        test_simultaneous();
        test_all_four();
        test_merge_loss();
        test_back_to_back();
        test_snapshot_hold();
        test_reset_midop_small();
        test_rollover();
        test_adjust_wrap();
        test_reset_midop_big();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
